// File: rtl/adder_pkg.sv
// Shared definitions for the sequential add/subtract unit: FSM states and slice width.
package adder_pkg;

    // Operands are processed in slices of this many bits, least significant slice first.
    localparam int SLICE_W = 4;

    // Control states of the iterative adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Four-bit carry-lookahead slice: propagate/generate, lookahead carries and sum bits.
// c[3] is the carry out of the slice and c[2] the carry into its top bit, which the
// top level uses for signed overflow detection on the most significant slice.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic [3:0] c
);

    logic [3:0] p;
    logic [3:0] g;

    // Flatten every carry into a two-level sum of products of p, g and cin.
    always_comb begin
        p = a ^ b;
        g = a & b;

        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

        s = p ^ {c[2:0], cin};
    end

endmodule

// File: rtl/seq_addsub.sv
// Iterative add/subtract unit. One 4-bit slice is added per cycle, LSB slice first,
// with the slice carry held in a register between cycles. Subtraction is a + ~b + 1:
// b is inverted when the request is accepted and the carry register starts at 1.
// WIDTH must be a multiple of 4 and at least 4.
module seq_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CNT_W+1:0]   shamt;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               c_out;
    logic               c_msb;
    logic [1:0]         c_low_unused;
    logic               last;

    // Pick the current slice out of the operand registers; slices are 4 bits, so the
    // bit offset is the slice index with two zero bits appended.
    always_comb begin
        shamt = {cnt, 2'b00};
        a_sl  = SLICE_W'(a_q >> shamt);
        b_sl  = SLICE_W'(b_q >> shamt);
        last  = (cnt == LAST_SLICE);
    end

    cla4_slice u_slice (
        .a   (a_sl),
        .b   (b_sl),
        .cin (carry),
        .s   (s_sl),
        .c   ({c_out, c_msb, c_low_unused})
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; acceptance and draining never overlap.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then fold one slice per RUN cycle into the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_q <= (sum_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(s_sl) << shamt);
                    carry <= c_out;
                    if (last) begin
                        cout_q <= c_out;
                        ovf_q  <= c_out ^ c_msb;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Testbench for seq_addsub: directed corner cases, random operations against an
// arithmetic reference model, back-pressure, back-to-back throughput, mid-run reset,
// and a second instance at WIDTH=4.
module tb_seq_addsub;

    localparam int W  = 16;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;
    logic          in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4;
    logic [W4-1:0] a4, b4, sum4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seq_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    seq_addsub #(.WIDTH(W4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .sub       (sub4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain unsigned and signed arithmetic on w-bit numbers.
    function automatic void model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                  input logic isub, output logic [15:0] es,
                                  output logic ec, output logic eo);
        longint m, ua, ub, sa, sb, r, sr;
        m  = longint'(1) << w;
        ua = longint'(ia) & (m - 1);
        ub = longint'(ib) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (isub) begin
            r  = ua - ub;
            ec = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            ec = (r >= m);
            sr = sa + sb;
        end
        eo = (sr >= m / 2) || (sr < -(m / 2));
        es = 16'(((r % m) + m) % m);
    endfunction

    // Drive one request on the 16-bit unit and wait for its result; leaves the unit in DONE.
    // lat counts clock edges after the accepting edge until out_valid is seen.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                          output int lat, output bit tmo);
        int n;
        tmo      = 1'b0;
        a        = ia;
        b        = ib;
        sub      = isub;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        sub      = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) tmo = 1'b1;
    endtask

    // Same as run_op, for the WIDTH=4 instance.
    task automatic run_op4(input logic [3:0] ia, input logic [3:0] ib, input logic isub,
                           output int lat, output bit tmo);
        int n;
        tmo       = 1'b0;
        a4        = ia;
        b4        = ib;
        sub4      = isub;
        in_valid4 = 1'b1;
        n = 0;
        while (!in_ready4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        a4        = 4'($urandom);
        b4        = 4'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid4) tmo = 1'b1;
    endtask

    // Outputs during and right after reset.
    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (sum !== 16'h0)      begin bad++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
        total++; if (cout !== 1'b0)      begin bad++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
        total++; if (ovf !== 1'b0)       begin bad++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        total++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_w4: got ready=%b valid=%b expected 1 0", in_ready4, out_valid4);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset_idle: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    // Hand-computed corner cases; out_valid must appear WIDTH/4 edges after the accepting edge.
    task automatic test_directed();
        typedef struct packed {
            logic [15:0] a;
            logic [15:0] b;
            logic        s;
            logic [15:0] es;
            logic        ec;
            logic        eo;
        } vec_t;
        vec_t vecs [6];
        int   lat;
        bit   tmo;
        vecs[0] = '{a: 16'h1234, b: 16'h4321, s: 1'b0, es: 16'h5555, ec: 1'b0, eo: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, s: 1'b0, es: 16'h0000, ec: 1'b1, eo: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, s: 1'b0, es: 16'h8000, ec: 1'b0, eo: 1'b1};
        vecs[3] = '{a: 16'h8000, b: 16'h0001, s: 1'b1, es: 16'h7FFF, ec: 1'b1, eo: 1'b1};
        vecs[4] = '{a: 16'h0005, b: 16'h0007, s: 1'b1, es: 16'hFFFE, ec: 1'b0, eo: 1'b0};
        vecs[5] = '{a: 16'h0007, b: 16'h0007, s: 1'b1, es: 16'h0000, ec: 1'b1, eo: 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, tmo);
            total++; if (tmo) begin bad++; $display("[TB] FAIL dir%0d_timeout: got no out_valid expected out_valid", i); end
            total++; if (lat != W / 4) begin bad++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, W / 4); end
            total++; if (sum !== vecs[i].es) begin bad++; $display("[TB] FAIL dir%0d_sum: got %h expected %h", i, sum, vecs[i].es); end
            total++; if (cout !== vecs[i].ec) begin bad++; $display("[TB] FAIL dir%0d_cout: got %b expected %b", i, cout, vecs[i].ec); end
            total++; if (ovf !== vecs[i].eo) begin bad++; $display("[TB] FAIL dir%0d_ovf: got %b expected %b", i, ovf, vecs[i].eo); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_ready_in_done: got %b expected 0", i, in_ready); end
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++; $display("[TB] FAIL dir%0d_drain: got ready=%b valid=%b expected 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    // Random operands, biased towards sign and carry boundaries, against the model.
    task automatic test_random();
        logic [15:0] ra, rb, es;
        logic        rs, ec, eo;
        int          lat;
        bit          tmo;
        logic [15:0] corners [4];
        corners[0] = 16'h0000;
        corners[1] = 16'hFFFF;
        corners[2] = 16'h7FFF;
        corners[3] = 16'h8000;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            rs = 1'($urandom);
            model(W, ra, rb, rs, es, ec, eo);
            run_op(ra, rb, rs, lat, tmo);
            total++;
            if (tmo || sum !== es || cout !== ec || ovf !== eo) begin
                bad++;
                $display("[TB] FAIL rand%0d a=%h b=%h sub=%b: got sum=%h c=%b v=%b expected sum=%h c=%b v=%b",
                         i, ra, rb, rs, sum, cout, ovf, es, ec, eo);
            end
            @(posedge clk); #1;
        end
    endtask

    // Result must hold while the consumer stalls; new requests are ignored meanwhile.
    task automatic test_backpressure();
        logic [15:0] es;
        logic        ec, eo;
        int          lat;
        bit          tmo;
        model(W, 16'hABCD, 16'h1234, 1'b1, es, ec, eo);
        out_ready = 1'b0;
        run_op(16'hABCD, 16'h1234, 1'b1, lat, tmo);
        total++; if (tmo) begin bad++; $display("[TB] FAIL bp_timeout: got no out_valid expected out_valid"); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
            out_ready = 1'b0;
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es || cout !== ec || ovf !== eo) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b sum=%h c=%b v=%b expected 1 0 %h %b %b",
                         i, out_valid, in_ready, sum, cout, ovf, es, ec, eo);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    // Producer keeps in_valid high and consumer keeps out_ready high: one op per WIDTH/4+2 cycles.
    task automatic test_back_to_back();
        logic [15:0] ra, rb, es;
        logic        rs, ec, eo;
        int          n, prev;
        prev      = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            a = ra; b = rb; sub = rs;
            model(W, ra, rb, rs, es, ec, eo);
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            total++;
            if (!out_valid || sum !== es || cout !== ec || ovf !== eo) begin
                bad++;
                $display("[TB] FAIL b2b%0d_result: got valid=%b sum=%h c=%b v=%b expected 1 %h %b %b",
                         i, out_valid, sum, cout, ovf, es, ec, eo);
            end
            if (i > 0) begin
                total++;
                if (cyc - prev != W / 4 + 2) begin
                    bad++; $display("[TB] FAIL b2b%0d_period: got %0d expected %0d", i, cyc - prev, W / 4 + 2);
                end
            end
            prev = cyc;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reset in the second RUN cycle clears everything at once; the next op is unaffected.
    task automatic test_reset_mid_run();
        int lat;
        bit tmo;
        out_ready = 1'b1;
        a = 16'h1234; b = 16'h1111; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_handshake: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
        total++; if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_result: got sum=%h c=%b v=%b expected 0000 0 0", sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, lat, tmo);
        total++; if (tmo || sum !== 16'h0100 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_next_op: got sum=%h c=%b v=%b expected 0100 0 0", sum, cout, ovf);
        end
        @(posedge clk); #1;
    endtask

    // WIDTH=4 instance: a single RUN cycle per operation.
    task automatic test_width4();
        logic [15:0] es;
        logic        ec, eo;
        logic [3:0]  ra, rb;
        logic        rs;
        int          lat;
        bit          tmo;
        out_ready4 = 1'b1;
        run_op4(4'hF, 4'h1, 1'b0, lat, tmo);
        total++; if (tmo || lat != 1) begin bad++; $display("[TB] FAIL w4_latency: got %0d expected 1", lat); end
        total++; if (sum4 !== 4'h0 || cout4 !== 1'b1 || ovf4 !== 1'b0) begin
            bad++; $display("[TB] FAIL w4_f_plus_1: got sum=%h c=%b v=%b expected 0 1 0", sum4, cout4, ovf4);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rs = 1'($urandom);
            model(W4, 16'(ra), 16'(rb), rs, es, ec, eo);
            run_op4(ra, rb, rs, lat, tmo);
            total++;
            if (tmo || sum4 !== es[3:0] || cout4 !== ec || ovf4 !== eo) begin
                bad++;
                $display("[TB] FAIL w4_rand%0d a=%h b=%h sub=%b: got sum=%h c=%b v=%b expected sum=%h c=%b v=%b",
                         i, ra, rb, rs, sum4, cout4, ovf4, es[3:0], ec, eo);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        a4         = '0;
        b4         = '0;
        sub4       = 1'b0;
        out_ready4 = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
